// File: rtl/plic_multi_context_claim_complete.sv
// PLIC claim/complete unit: per-context priority arbitration, claim on read,
// complete on write, with a shared in-service mask across all hart contexts.
module plic_multi_context_claim_complete #(
  parameter int          N_INTERRUPTS = 32,
  parameter int          N_CONTEXTS   = 2,
  parameter int          PRIO_W       = 3,
  parameter int          ID_W         = 5,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0200
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [N_INTERRUPTS-1:0]          pending,
  input  logic [N_INTERRUPTS*PRIO_W-1:0]   priority_flat,
  input  logic [N_CONTEXTS*N_INTERRUPTS-1:0] enable_flat,
  input  logic [N_CONTEXTS*PRIO_W-1:0]     threshold_flat,
  input  logic [31:0]                      addr,
  input  logic                             wen,
  input  logic                             ren,
  input  logic [31:0]                      wdata,
  output logic [31:0]                      rdata,
  output logic                             addr_valid,
  output logic [N_CONTEXTS-1:0]            irq,
  output logic [N_INTERRUPTS-1:0]          claim_pulse,
  output logic [N_INTERRUPTS-1:0]          complete_pulse,
  output logic [N_CONTEXTS-1:0]            complete_err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CLAIMED = 1'b1;

  logic [N_CONTEXTS-1:0]      ctx_hit;
  logic [N_CONTEXTS-1:0]      ctx_rd;
  logic [N_CONTEXTS-1:0]      ctx_claim;
  logic [N_CONTEXTS-1:0]      ctx_complete;
  logic [N_CONTEXTS-1:0]      ctx_err;
  logic [N_CONTEXTS-1:0]      hit_prev_reg;
  logic [N_CONTEXTS*ID_W-1:0] best_id_flat;
  logic [N_CONTEXTS*ID_W-1:0] owned_id_flat;

  logic [N_INTERRUPTS-1:0] in_service_reg;
  logic [N_INTERRUPTS-1:0] in_service_next;
  logic [N_INTERRUPTS-1:0] claim_vec;
  logic [N_INTERRUPTS-1:0] complete_vec;
  logic [N_INTERRUPTS-1:0] claim_pulse_reg;
  logic [N_INTERRUPTS-1:0] complete_pulse_reg;
  logic [N_CONTEXTS-1:0]   complete_err_reg;

  logic unused_top;
  assign unused_top = &{1'b0, addr[1:0], wdata[31:ID_W], pending[0],
                        priority_flat[PRIO_W-1:0]};

  generate
    for (genvar gi = 0; gi < N_CONTEXTS; gi++) begin : g_ctx
      localparam logic [31:0] CTX_ADDR = BASE_ADDR + 32'(4 * gi);

      logic [0:0]        state_reg;
      logic [ID_W-1:0]   owned_id_reg;
      logic [ID_W-1:0]   best_id_reg;
      logic [PRIO_W-1:0] best_prio_reg;
      logic [ID_W-1:0]   win_id;
      logic [PRIO_W-1:0] win_prio;
      logic              unused_ctx;

      assign unused_ctx = &{1'b0, enable_flat[gi*N_INTERRUPTS], best_prio_reg};

      // Byte offsets alias to the word, so only addr[31:2] takes part in the match.
      assign ctx_hit[gi] = (addr[31:2] == CTX_ADDR[31:2]);

      // A claim needs a fresh read on this word; a write in the same cycle wins.
      assign ctx_claim[gi]    = ctx_hit[gi] & ren & ~wen & ~hit_prev_reg[gi] &
                                (state_reg == ST_IDLE) & (best_id_reg != '0);
      assign ctx_complete[gi] = ctx_hit[gi] & wen & (state_reg == ST_CLAIMED) &
                                (wdata[ID_W-1:0] == owned_id_reg);
      assign ctx_err[gi]      = ctx_hit[gi] & wen & ~ctx_complete[gi];
      assign ctx_rd[gi]       = ctx_hit[gi] & ren & ~wen & (state_reg == ST_IDLE);
      assign irq[gi]          = (state_reg == ST_IDLE) & (best_id_reg != '0);

      assign best_id_flat[gi*ID_W +: ID_W]  = best_id_reg;
      assign owned_id_flat[gi*ID_W +: ID_W] = owned_id_reg;

      // Ascending scan with strict '>' keeps the lowest ID on a priority tie;
      // starting from the threshold enforces priority > threshold.
      always_comb begin
        win_id   = '0;
        win_prio = threshold_flat[gi*PRIO_W +: PRIO_W];
        for (int i = 1; i < N_INTERRUPTS; i++) begin
          if (pending[i] && enable_flat[gi*N_INTERRUPTS + i] && !in_service_next[i] &&
              (priority_flat[i*PRIO_W +: PRIO_W] > win_prio)) begin
            win_id   = ID_W'(i);
            win_prio = priority_flat[i*PRIO_W +: PRIO_W];
          end
        end
        if (win_id == '0) begin
          win_prio = '0;
        end
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          state_reg     <= ST_IDLE;
          owned_id_reg  <= '0;
          best_id_reg   <= '0;
          best_prio_reg <= '0;
        end else begin
          best_id_reg   <= win_id;
          best_prio_reg <= win_prio;
          if (ctx_claim[gi]) begin
            state_reg    <= ST_CLAIMED;
            owned_id_reg <= best_id_reg;
          end else if (ctx_complete[gi]) begin
            state_reg <= ST_IDLE;
          end
        end
      end
    end
  endgenerate

  assign addr_valid = |ctx_hit;

  // Arbitration uses the post-claim mask so a just-claimed ID never reaches
  // another context's best_id, even for one cycle.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int c = 0; c < N_CONTEXTS; c++) begin
      if (ctx_claim[c]) begin
        claim_vec[best_id_flat[c*ID_W +: ID_W]] = 1'b1;
      end
      if (ctx_complete[c]) begin
        complete_vec[owned_id_flat[c*ID_W +: ID_W]] = 1'b1;
      end
    end
    in_service_next = (in_service_reg | claim_vec) & ~complete_vec;
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < N_CONTEXTS; c++) begin
      if (ctx_rd[c]) begin
        rdata = rdata | 32'(best_id_flat[c*ID_W +: ID_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_service_reg     <= '0;
      hit_prev_reg       <= '0;
      claim_pulse_reg    <= '0;
      complete_pulse_reg <= '0;
      complete_err_reg   <= '0;
    end else begin
      in_service_reg     <= in_service_next;
      hit_prev_reg       <= ctx_hit & {N_CONTEXTS{ren}};
      claim_pulse_reg    <= claim_vec;
      complete_pulse_reg <= complete_vec;
      complete_err_reg   <= ctx_err;
    end
  end

  assign claim_pulse    = claim_pulse_reg;
  assign complete_pulse = complete_pulse_reg;
  assign complete_err   = complete_err_reg;

endmodule

// File: tb/tb_plic_multi_context_claim_complete.sv
// Directed bench for plic_multi_context_claim_complete: claim, complete, errors,
// threshold, held-read and reset-while-claimed scenarios.
module tb_plic_multi_context_claim_complete;

  localparam int          NI   = 32;
  localparam int          NC   = 2;
  localparam int          PW   = 3;
  localparam int          IW   = 5;
  localparam logic [31:0] BASE = 32'h0000_0200;

  logic             clk;
  logic             n_rst;
  logic [NI-1:0]    pending;
  logic [NI*PW-1:0] priority_flat;
  logic [NC*NI-1:0] enable_flat;
  logic [NC*PW-1:0] threshold_flat;
  logic [31:0]      addr;
  logic             wen;
  logic             ren;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             addr_valid;
  logic [NC-1:0]    irq;
  logic [NI-1:0]    claim_pulse;
  logic [NI-1:0]    complete_pulse;
  logic [NC-1:0]    complete_err;

  int checks = 0;
  int fails  = 0;
  int n_claims;

  plic_multi_context_claim_complete #(
    .N_INTERRUPTS(NI), .N_CONTEXTS(NC), .PRIO_W(PW), .ID_W(IW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .n_rst(n_rst), .pending(pending), .priority_flat(priority_flat),
    .enable_flat(enable_flat), .threshold_flat(threshold_flat), .addr(addr),
    .wen(wen), .ren(ren), .wdata(wdata), .rdata(rdata), .addr_valid(addr_valid),
    .irq(irq), .claim_pulse(claim_pulse), .complete_pulse(complete_pulse),
    .complete_err(complete_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s ok observed=%0h", tag, obs);
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ren = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic set_prio(input int i, input int p);
    priority_flat[i*PW +: PW] = p[PW-1:0];
  endtask

  task automatic set_en(input int c, input int i);
    enable_flat[c*NI + i] = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; pending = '0; priority_flat = '0; enable_flat = '0;
    threshold_flat = '0; addr = 32'h0; wen = 1'b0; ren = 1'b0; wdata = 32'h0;
    repeat (2) cyc();
    addr = BASE; ren = 1'b1; #1;
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_claim", 64'(claim_pulse), 64'd0);
    check("addr_valid_hit", 64'(addr_valid), 64'd1);
    addr = BASE + 32'd9; #1;
    check("addr_valid_miss", 64'(addr_valid), 64'd0);
    idle_bus();
    n_rst = 1'b1;
    cyc();

    // Single source 5 on ctx0
    set_prio(5, 3); set_en(0, 5); pending[5] = 1'b1; #1;
    check("t1_irq_pre", 64'(irq[0]), 64'd0);
    cyc();
    check("t1_irq", 64'(irq[0]), 64'd1);
    addr = BASE + 32'd2; ren = 1'b1; #1;
    check("t1_rdata", 64'(rdata), 64'd5);
    cyc(); idle_bus(); pending[5] = 1'b0;
    check("t1_claim_pulse", 64'(claim_pulse), 64'd1 << 5);
    check("t1_irq_off", 64'(irq[0]), 64'd0);
    cyc();
    check("t1_pulse_single", 64'(claim_pulse), 64'd0);
    addr = BASE; wen = 1'b1; wdata = 32'd5;
    cyc(); idle_bus();
    check("t1_complete", 64'(complete_pulse), 64'd1 << 5);
    check("t1_no_err", 64'(complete_err), 64'd0);

    // Priority and tie-break; ctx1 enabled only for 9
    set_prio(3, 2); set_prio(7, 2); set_prio(9, 4);
    set_en(0, 3); set_en(0, 7); set_en(0, 9); set_en(1, 9);
    pending[3] = 1'b1; pending[7] = 1'b1; pending[9] = 1'b1;
    cyc();
    check("t2_irq_both", 64'(irq), 64'd3);
    addr = BASE; ren = 1'b1; #1;
    check("t2_rdata_9", 64'(rdata), 64'd9);
    cyc(); idle_bus();
    check("t2_claim_9", 64'(claim_pulse), 64'd1 << 9);
    check("t3_ctx1_masked", 64'(irq), 64'd0);
    addr = BASE + 32'd4; ren = 1'b1; #1;
    check("t3_ctx1_read", 64'(rdata), 64'd0);
    cyc(); idle_bus();
    check("t3_ctx1_noclaim", 64'(claim_pulse), 64'd0);

    // Wrong-ID complete and read while claimed
    addr = BASE; wen = 1'b1; wdata = 32'd4;
    cyc(); idle_bus();
    check("t4_err", 64'(complete_err), 64'd1);
    check("t4_no_complete", 64'(complete_pulse), 64'd0);
    addr = BASE; ren = 1'b1; #1;
    check("t4_read_claimed", 64'(rdata), 64'd0);
    cyc(); idle_bus();
    check("t4_noclaim", 64'(claim_pulse), 64'd0);
    check("t4_still_in_service", 64'(irq[1]), 64'd0);
    addr = BASE; wen = 1'b1; wdata = 32'd9;
    cyc(); idle_bus(); pending[9] = 1'b0;
    check("t3_complete_9", 64'(complete_pulse), 64'd1 << 9);
    check("t3_complete_noerr", 64'(complete_err), 64'd0);
    cyc();
    check("t2_irq_after", 64'(irq), 64'd1);
    addr = BASE; ren = 1'b1; #1;
    check("t2_tie_low_id", 64'(rdata), 64'd3);
    cyc(); idle_bus();
    check("t2_claim_3", 64'(claim_pulse), 64'd1 << 3);
    addr = BASE; wen = 1'b1; wdata = 32'd3;
    cyc(); idle_bus(); pending[3] = 1'b0;
    check("t2_complete_3", 64'(complete_pulse), 64'd1 << 3);
    cyc();
    addr = BASE; ren = 1'b1; #1;
    check("t2_rdata_7", 64'(rdata), 64'd7);
    cyc(); idle_bus();
    check("t2_claim_7", 64'(claim_pulse), 64'd1 << 7);
    addr = BASE; wen = 1'b1; wdata = 32'd7;
    cyc(); idle_bus(); pending[7] = 1'b0;
    check("t2_complete_7", 64'(complete_pulse), 64'd1 << 7);
    cyc();

    // Threshold equal to priority blocks the source
    threshold_flat[0 +: PW] = 3'd4;
    set_prio(12, 4); set_en(0, 12); pending[12] = 1'b1;
    cyc(); cyc();
    check("t5_irq_thr", 64'(irq[0]), 64'd0);
    addr = BASE; ren = 1'b1; #1;
    check("t5_rdata_thr", 64'(rdata), 64'd0);
    cyc(); idle_bus();
    check("t5_noclaim_thr", 64'(claim_pulse), 64'd0);
    threshold_flat[0 +: PW] = 3'd3;
    cyc();
    check("t5_irq_open", 64'(irq[0]), 64'd1);

    // Held read yields exactly one claim
    addr = BASE; ren = 1'b1; #1;
    check("t5_rdata_12", 64'(rdata), 64'd12);
    n_claims = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_claims += int'(claim_pulse[12]);
    end
    check("t5_held_rdata", 64'(rdata), 64'd0);
    idle_bus();
    cyc();
    n_claims += int'(claim_pulse[12]);
    check("t5_one_claim", 64'(n_claims), 64'd1);

    // Simultaneous write and read: complete wins, no claim
    addr = BASE; wen = 1'b1; ren = 1'b1; wdata = 32'd12; #1;
    check("t5_wr_rd_rdata", 64'(rdata), 64'd0);
    cyc(); idle_bus(); pending[12] = 1'b0; threshold_flat = '0;
    check("t5_wr_rd_complete", 64'(complete_pulse), 64'd1 << 12);
    check("t5_wr_rd_noclaim", 64'(claim_pulse), 64'd0);

    // Reset while ctx1 holds a claim
    set_prio(20, 5); set_en(1, 20); pending[20] = 1'b1;
    cyc();
    check("t6_irq1", 64'(irq), 64'd2);
    addr = BASE + 32'd4; ren = 1'b1; #1;
    check("t6_rdata_20", 64'(rdata), 64'd20);
    cyc(); idle_bus();
    check("t6_claim_20", 64'(claim_pulse), 64'd1 << 20);
    check("t6_irq1_off", 64'(irq[1]), 64'd0);
    addr = BASE + 32'd4; ren = 1'b1; n_rst = 1'b0; #1;
    check("t6_rst_irq", 64'(irq), 64'd0);
    check("t6_rst_rdata", 64'(rdata), 64'd0);
    check("t6_rst_claim", 64'(claim_pulse), 64'd0);
    check("t6_rst_err", 64'(complete_err), 64'd0);
    cyc();
    check("t6_rst_complete", 64'(complete_pulse), 64'd0);
    idle_bus(); n_rst = 1'b1;
    cyc(); cyc();
    check("t6_irq_again", 64'(irq), 64'd2);
    addr = BASE + 32'd4; ren = 1'b1; #1;
    check("t6_reclaim_rdata", 64'(rdata), 64'd20);
    cyc(); idle_bus();
    check("t6_reclaim_pulse", 64'(claim_pulse), 64'd1 << 20);
    check("t6_no_complete", 64'(complete_pulse), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/plic_multi_context_claim_complete.md
Name: plic_multi_context_claim_complete

Overview:
Parametrised PLIC claim/complete unit serving N_CONTEXTS hart contexts, each with its own memory-mapped claim/complete word.
- Per cycle and per context, selects the highest-priority pending, enabled interrupt above that context's threshold.
- Claim reads hand that ID out and tell the gateway to clear its pending bit; complete writes re-arm the gateway.
- Sits between the interrupt gateways/priority registers and the APB/AHB slave mux of the interrupt controller.

Parameters:
N_INTERRUPTS, 32, source count including reserved ID 0 (never a real source)
N_CONTEXTS, 2, number of hart contexts; each owns one claim/complete word
PRIO_W, 3, priority width; priority 0 = never interrupts
ID_W, 5, ID width; must satisfy 2**ID_W >= N_INTERRUPTS
BASE_ADDR, 32'h0000_0200, address of context 0 word; context c at BASE_ADDR+4*c

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
pending  in  N_INTERRUPTS  gateway pending bits; bit 0 ignored
priority_flat  in  N_INTERRUPTS*PRIO_W  source i priority in bits [i*PRIO_W +: PRIO_W]
enable_flat  in  N_CONTEXTS*N_INTERRUPTS  context c enable for source i at bit c*N_INTERRUPTS+i
threshold_flat  in  N_CONTEXTS*PRIO_W  per-context threshold
addr  in  32  bus address
wen  in  1  bus write strobe
ren  in  1  bus read strobe
wdata  in  32  bus write data; low ID_W bits = completed ID
rdata  out  32  bus read data
addr_valid  out  1  addr hits any context word
irq  out  N_CONTEXTS  interrupt request to each hart
claim_pulse  out  N_INTERRUPTS  1-cycle pulse: gateway clears pending for that ID
complete_pulse  out  N_INTERRUPTS  1-cycle pulse: gateway re-armed for that ID
complete_err  out  N_CONTEXTS  1-cycle pulse: complete with non-matching ID

Behaviour:
- Decode: addr_valid = BASE_ADDR <= addr < BASE_ADDR+4*N_CONTEXTS. ctx = (addr-BASE_ADDR)>>2. Byte offsets within a word alias to that word.
- Arbiter, per context c:
  - candidate i requires pending[i], enable, priority > threshold[c], not in_service[i], and i != 0.
  - Winner is the highest priority; ties go to the lowest ID.
  - Result is registered into best_id[c] (ID_W bits) and best_prio[c] each cycle: one-cycle latency from input change to best_id.
- in_service: N_INTERRUPTS-bit register. Claimed IDs are excluded from every context's arbitration until completed.
- Context FSM, per context: IDLE, CLAIMED(owned_id).
  - IDLE, read hit with ren rising edge (ren & !ren_prev, same address): owned_id <= best_id[c].
    - If best_id != 0: set in_service[best_id]; claim_pulse[best_id] = 1 for one cycle; go CLAIMED.
    - If best_id == 0: stay IDLE, no pulse.
  - CLAIMED, write hit with wen and wdata[ID_W-1:0] == owned_id: clear in_service[owned_id]; complete_pulse[owned_id] = 1 for one cycle; go IDLE.
  - CLAIMED, write hit with non-matching ID: complete_err[c] = 1 for one cycle; state unchanged.
  - IDLE, write hit: complete_err[c] = 1; ignored.
  - CLAIMED, read hit: rdata = 0; no new claim (one outstanding claim per context).
- Held ren generates exactly one claim. A new claim requires ren to deassert, or the address to change to another context.
- rdata (combinational): addr_valid & ren & ctx IDLE -> {zero-extend best_id[ctx]}; otherwise 0. The value returned equals the ID claimed in that cycle.
- irq[c] = (state IDLE) & (best_id[c] != 0). Registered-path only, no combinational loop to bus inputs.
- Simultaneous wen and ren on the same word: write (complete) takes precedence; read returns 0 that cycle and claims nothing.
- Complete and a new pending of the same ID in one cycle: complete_pulse issued; the ID may win arbitration from the next cycle.
- Context-0 claim and context-1 complete in one cycle: impossible (single bus), so no arbitration between contexts is needed.
- Reset, including mid-claim:
  - state = IDLE; in_service, best_id, best_prio, ren_prev = 0.
  - irq, claim_pulse, complete_pulse, complete_err = 0; rdata = 0.
  - Outstanding claims are dropped; no complete_pulse is emitted for them.

Test Plan:
- Reset then pending[5]=1, prio 3, ctx0 enabled, threshold 0 -> irq[0]=1 one cycle after pending; read BASE_ADDR -> rdata=5, claim_pulse[5] one cycle, irq[0]=0.
- pending[3] and [7] both prio 2, plus [9] prio 4 -> ctx0 claims 9; then 3 (lowest ID on tie); [7] stays in arbitration.
- Claimed ID 9 on ctx0 with ctx1 also enabled for 9 -> ctx1 best_id != 9 while in service; write 9 to BASE_ADDR -> complete_pulse[9], ctx0 IDLE.
- Write 4 to ctx0 while it owns 9 -> complete_err[0]=1, in_service[9] stays; second read to ctx0 returns 0.
- Threshold 4, only source priority 4 pending -> irq=0, read returns 0, no claim_pulse; ren held 3 cycles with valid ID -> exactly one claim_pulse.
- Assert n_rst low while ctx1 in CLAIMED -> all outputs 0; after release in_service clear and the same ID is claimable again.
